// File: rtl/relu_max_pool_pkg.sv
// ---------------------------------------------------------------------------
// relu_max_pool_pkg
// Shared layer package for the post-convolution stages.
//   - ACC_WIDTH / PIX_WIDTH : accumulator and requantised pixel widths
//   - acc_t / pix_t         : matching signed accumulator / unsigned pixel types
//   - pool_action_e         : what the pooling stage does with a stage-1 pixel
//   - requant()             : ReLU, arithmetic right shift, saturate to 8 bits
//                             (also used by the fully-connected output stage)
//   - pix_max()             : unsigned 8-bit maximum
// ---------------------------------------------------------------------------
package relu_max_pool_pkg;

   localparam int ACC_WIDTH = 32;
   localparam int PIX_WIDTH = 8;
   localparam int PIX_MAX   = (1 << PIX_WIDTH) - 1;

   typedef logic signed [ACC_WIDTH-1:0] acc_t;
   typedef logic        [PIX_WIDTH-1:0] pix_t;

   typedef enum logic [1:0] {
      POOL_NONE,
      POOL_HOLD,
      POOL_STORE,
      POOL_EMIT
   } pool_action_e;

   // Negative accumulators clamp to zero; positive ones are scaled down by
   // the shift and then clamped to the largest representable pixel.
   function automatic pix_t requant(input acc_t acc, input int shift);
      acc_t scaled;
      pix_t q;
      scaled = acc >>> shift;
      q      = '0;
      if (acc < 0) begin
         q = '0;
      end else if (scaled > acc_t'(PIX_MAX)) begin
         q = pix_t'(PIX_MAX);
      end else begin
         q = scaled[PIX_WIDTH-1:0];
      end
      return q;
   endfunction

   function automatic pix_t pix_max(input pix_t a, input pix_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// ---------------------------------------------------------------------------
// pool_line_buf
// Simple dual-port RAM holding one horizontal pair-maximum per pooling window
// column. Written during even rows, read back during the odd row below.
//   clock   : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data
// Contents are deliberately not reset so it maps onto distributed RAM.
// ---------------------------------------------------------------------------
module pool_line_buf #(
   parameter int DEPTH      = 14,
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clock,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Single write port; no reset so the array stays a plain RAM.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Asynchronous read: the pooling stage consumes the value in the same
   // cycle it presents the address. Reads and writes always belong to rows of
   // opposite parity, so no write-to-read bypass is required.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/relu_max_pool.sv
// ---------------------------------------------------------------------------
// relu_max_pool
// Requantises the convolution accumulator stream (ReLU, >>> SHIFT, saturate
// to 8 bits) and applies 2x2 stride-2 max pooling in raster order.
//   clock           : rising-edge clock
//   reset           : synchronous, active-high
//   pixel_in        : signed conv accumulator
//   pixel_valid_in  : pixel_in valid this cycle (gaps freeze the pipeline)
//   pixel_out       : unsigned pooled pixel
//   pixel_valid_out : one-cycle pulse per pooled pixel
//   frame_done      : one-cycle pulse when the last input pixel of a frame
//                     leaves the pooling stage
// ---------------------------------------------------------------------------
module relu_max_pool
   import relu_max_pool_pkg::*;
#(
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28,
   parameter int SHIFT      = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic signed [ACC_WIDTH-1:0] pixel_in,
   input  logic                        pixel_valid_in,
   output logic        [PIX_WIDTH-1:0] pixel_out,
   output logic                        pixel_valid_out,
   output logic                        frame_done
);

   localparam int CW       = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int LB_DEPTH = (IMG_WIDTH / 2 > 0) ? IMG_WIDTH / 2 : 1;
   localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic          s1_valid;
   pix_t          s1_q;
   logic [CW-1:0] s1_col;
   logic [RW-1:0] s1_row;

   pix_t          hold;
   pool_action_e  action;
   pix_t          pair_max;
   pix_t          window_max;
   logic [AW-1:0] lb_addr;
   pix_t          lb_rd_data;

   // Raster position of the incoming pixel. Only valid inputs advance it, so
   // gaps in the stream leave the position untouched.
   always_ff @(posedge clock) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (pixel_valid_in) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Stage 1: requantise and tag the pixel with its position. The valid flag
   // follows the input every cycle; the data only moves on valid inputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
         s1_col   <= '0;
         s1_row   <= '0;
      end else begin
         s1_valid <= pixel_valid_in;
         if (pixel_valid_in) begin
            s1_q   <= requant(pixel_in, SHIFT);
            s1_col <= col;
            s1_row <= row;
         end
      end
   end

   // Decide what stage 2 does with the stage-1 pixel. Even columns open a
   // horizontal pair; odd columns close it and either park the pair maximum
   // (even row) or combine it with the parked value from the row above
   // (odd row). A trailing unpaired column lands on an even column and is
   // simply overwritten later; a trailing unpaired row only ever stores.
   always_comb begin
      action = POOL_NONE;
      if (s1_valid) begin
         if (!s1_col[0]) begin
            action = POOL_HOLD;
         end else if (!s1_row[0]) begin
            action = POOL_STORE;
         end else begin
            action = POOL_EMIT;
         end
      end
   end

   assign pair_max   = pix_max(hold, s1_q);
   assign window_max = pix_max(lb_rd_data, pair_max);
   assign lb_addr    = AW'(s1_col >> 1);

   pool_line_buf #(
      .DEPTH      (LB_DEPTH),
      .WIDTH      (PIX_WIDTH),
      .ADDR_WIDTH (AW)
   ) u_line_buf (
      .clock   (clock),
      .wr_en   (action == POOL_STORE),
      .wr_addr (lb_addr),
      .wr_data (pair_max),
      .rd_addr (lb_addr),
      .rd_data (lb_rd_data)
   );

   // Stage 2: hold register and registered outputs. The valid and frame-done
   // strobes are recomputed every cycle so they are always single pulses;
   // frame_done tracks the last input position even for odd dimensions.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold            <= '0;
         pixel_out       <= '0;
         pixel_valid_out <= 1'b0;
         frame_done      <= 1'b0;
      end else begin
         pixel_valid_out <= (action == POOL_EMIT);
         frame_done      <= s1_valid && (s1_col == COL_LAST) && (s1_row == ROW_LAST);
         case (action)
            POOL_HOLD: hold      <= s1_q;
            POOL_EMIT: pixel_out <= window_max;
            default:   ;
         endcase
      end
   end

endmodule

// File: doc/relu_max_pool.md
Name: relu_max_pool

Overview:
- Downstream stage of the convolution layer; consumes its 32-bit signed accumulator stream in raster order.
- Each pixel is requantised (ReLU, arithmetic right shift, saturation to 8-bit unsigned).
- The block then applies 2x2 stride-2 max pooling using a half-width line buffer.
- Emits an 8-bit pooled stream for the next layer's shift register, plus an end-of-frame pulse.

Parameters:
- IMG_WIDTH, 28, input pixels per row (conv output width).
- IMG_HEIGHT, 28, input rows per frame.
- SHIFT, 8, right-shift applied to the accumulator before saturation; range 0..23.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- pixel_in  input  32  signed conv accumulator, two's complement.
- pixel_valid_in  input  1  pixel_in is valid this cycle.
- pixel_out  output  8  unsigned pooled pixel.
- pixel_valid_out  output  1  pixel_out is valid this cycle; single-cycle pulse per pooled pixel.
- frame_done  output  1  one-cycle pulse when the final input pixel of a frame has been processed.

Behaviour:
- Reset: synchronous, active-high.
  - On reset, pixel_out=0, pixel_valid_out=0 and frame_done=0.
  - Column and row counters go to 0; hold register and stage-1 registers go to 0.
  - Line buffer contents are not reset.
- Reset mid-frame: discards the partial frame. The first valid pixel after reset is position (row 0, col 0).
- No backpressure: input gaps (pixel_valid_in=0) freeze all state. Outputs are valid only on pulse cycles.
- Counters: col advances on each valid input and wraps at IMG_WIDTH-1 to 0, incrementing row. Row wraps at IMG_HEIGHT-1 to 0.
- Stage 1 (registered, 1 cycle), on a valid input:
  - If pixel_in<0, q=0.
  - Otherwise s=pixel_in>>>SHIFT; q=255 if s>255, else s[7:0].
  - q is registered with its col/row and a stage-1 valid flag.
- Stage 2 (registered, 1 cycle), on a stage-1 valid:
  - Even col: hold <= q.
  - Odd col, even row: line_buf[col>>1] <= max(hold,q).
  - Odd col, odd row: pixel_out <= max(line_buf[col>>1], max(hold,q)); pixel_valid_out=1.
- Line buffer: depth IMG_WIDTH/2, width 8.
  - One write port and one read port, both addressed by col>>1.
  - Read is combinational, or an equivalent registered read timed to the same cycle.
  - Read and write never target the same row parity in the same cycle, so no bypass is needed.
- Latency: pixel_valid_out rises exactly 2 cycles after the valid input of the bottom-right pixel of each 2x2 window.
- frame_done: asserted in the same cycle stage 2 would output for position (IMG_HEIGHT-1, IMG_WIDTH-1), i.e. 2 cycles after that input.
  - For even dimensions it coincides with the last pixel_valid_out.
  - The position is tracked even if IMG_WIDTH or IMG_HEIGHT is odd.
- Odd dimensions: the trailing column or row that has no partner is ignored; no output is produced for it.
- Output count per frame: floor(IMG_WIDTH/2)*floor(IMG_HEIGHT/2).
- Back-to-back frames: there is no idle cycle between frames. Row 0 of the next frame may enter while stage 2 finishes the previous frame.
- Comparisons are unsigned on 8-bit values. Ties select either operand; the result is identical.

Decomposition:
- Shared layer package holds:
  - the pixel-width constants (ACC_WIDTH=32, PIX_WIDTH=8);
  - a requant function (ReLU/shift/saturate) that the fully-connected output stage reuses.
- One sub-module: pool_line_buf, a simple dual-port RAM (depth, width parameters), inferable as distributed RAM.
- Counters and the pooling datapath stay in the top module.

Test Plan:
- Requant corners, 1x2 window via 4x4 frame, SHIFT=8:
  - inputs -5 -> 0; 0x0000_7F00 -> 127; 0x0001_0000 -> 255 (saturated); 0x0000_00FF -> 0.
  - Check via a frame where each window contains only that value.
- Basic pool, IMG_WIDTH=4, IMG_HEIGHT=2, SHIFT=0, inputs 1,2,3,4 / 5,6,7,8 contiguous:
  - outputs 6 then 8.
  - pixel_valid_out 2 cycles after the inputs 6 and 8.
  - frame_done coincident with the second output.
- Valid gaps: same frame with pixel_valid_in toggling 1,0,0,1,...
  - Outputs are identical (6, 8), each 2 cycles after its triggering input.
  - No spurious pulses.
- Reset mid-frame: 4x4 frame, assert reset after 6 pixels, then send a full frame.
  - Only the 4 outputs of the new frame appear, with correct values.
  - Outputs are 0 and pixel_valid_out is 0 during reset.
- Back-to-back frames, 28x28 random signed data, SHIFT=8:
  - 196 outputs per frame, matching the reference model.
  - frame_done once per frame.
- Odd dims, IMG_WIDTH=5, IMG_HEIGHT=3, SHIFT=0, inputs 0..14:
  - outputs 6 and 8 (the last column and last row are dropped).
  - frame_done 2 cycles after input 14.
